// File: rtl/bus_dev_pkg.sv
// Shared constants, error-bit indices and packet helpers for the bus device port.
package bus_dev_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned MAX_PKT_W = 64;

  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    ERR_POP_UNDERFLOW = 2'd0,
    ERR_TX_OVF        = 2'd1,
    ERR_RX_DROP       = 2'd2
  } err_idx_e;

  // Packets narrower than MAX_PKT_W are passed zero-extended with their true width.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                              input int unsigned           pkt_w);
    logic [MAX_PKT_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module bus_dev_fifo
  import bus_dev_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [W-1:0]                 wdata,
  input  logic                         rd,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  // A read frees a slot in the same cycle, so a write while full is accepted alongside it.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side endpoint of the bus arbiter protocol: TX FIFO toward the arbiter, RX FIFO from it.
// Optional destination filtering on receive is enabled by defining BUS_DEV_RX_FILTER_EN.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     depth     = 8,
  parameter logic [ID_W-1:0] dev_id    = '0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_empty,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  output logic [$clog2(depth+1)-1:0]   tx_cnt,
  output logic [$clog2(depth+1)-1:0]   rx_cnt,
  output logic [ERR_W-1:0]             err,
  input  logic                         err_clr
);

  logic             tx_empty;
  logic             rx_full;
  logic             rx_accept;
  logic             rx_push;
  logic [ERR_W-1:0] err_next;

`ifdef BUS_DEV_RX_FILTER_EN
  logic [ID_W-1:0] dest;
  assign dest      = dest_of(MAX_PKT_W'(D_push), pckg_sz);
  assign rx_accept = (dest == dev_id) || (dest == broadcast);
`else
  assign rx_accept = 1'b1;
`endif

  assign rx_push = push && rx_accept;
  assign pndng   = !tx_empty;

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
    .clk   (clk),
    .rst   (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .cnt   (tx_cnt)
  );

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
    .clk   (clk),
    .rst   (reset),
    .wr    (rx_push),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .cnt   (rx_cnt)
  );

  // Clear is applied first so an error event in the same cycle keeps its bit set.
  always_comb begin
    err_next = err_clr ? '0 : err;
    if (pop && tx_empty)                 err_next[ERR_POP_UNDERFLOW] = 1'b1;
    if (tx_wr && tx_full && !pop)        err_next[ERR_TX_OVF]        = 1'b1;
    if (rx_push && rx_full && !rx_rd)    err_next[ERR_RX_DROP]       = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else       err <= err_next;
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Directed bench for bus_dev_port with a queue-based reference model checked every cycle.
module tb_bus_dev_port;

`ifdef BUS_DEV_RX_FILTER_EN
  localparam logic [7:0] DEV    = 8'h02;
  localparam bit         FILTER = 1'b1;
`else
  localparam logic [7:0] DEV    = 8'h00;
  localparam bit         FILTER = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, rx_rd, pop, push, err_clr;
  logic [15:0] tx_data, D_push;
  logic        tx_full, rx_empty, pndng;
  logic [15:0] rx_data, D_pop;
  logic [3:0]  tx_cnt, rx_cnt;
  logic [2:0]  err;

  int checks = 0;
  int passes = 0;

  bus_dev_port #(.pckg_sz(16), .depth(DEPTH), .dev_id(DEV), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: packet queues plus sticky error bits.
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [2:0]  err_m;

  always @(posedge clk or posedge reset) begin
    bit          tx_popped, tx_take, rx_read, rx_keep, rx_take;
    logic [2:0]  e;
    if (reset) begin
      txq.delete();
      rxq.delete();
      err_m = 3'b000;
    end else begin
      e         = err_clr ? 3'b000 : err_m;
      tx_popped = pop && (txq.size() > 0);
      tx_take   = tx_wr && ((txq.size() < DEPTH) || tx_popped);
      if (pop && txq.size() == 0) e[0] = 1'b1;
      if (tx_wr && !tx_take)      e[1] = 1'b1;
      rx_read   = rx_rd && (rxq.size() > 0);
      rx_keep   = push && (!FILTER || D_push[15:8] == DEV || D_push[15:8] == 8'hFF);
      rx_take   = rx_keep && ((rxq.size() < DEPTH) || rx_read);
      if (rx_keep && !rx_take)    e[2] = 1'b1;
      if (tx_popped) void'(txq.pop_front());
      if (tx_take)   txq.push_back(tx_data);
      if (rx_read)   void'(rxq.pop_front());
      if (rx_take)   rxq.push_back(D_push);
      err_m = e;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      cmp("m_pndng",    pndng,    txq.size() != 0);
      cmp("m_D_pop",    D_pop,    (txq.size() != 0) ? txq[0] : 16'h0);
      cmp("m_tx_full",  tx_full,  txq.size() == DEPTH);
      cmp("m_tx_cnt",   tx_cnt,   txq.size());
      cmp("m_rx_empty", rx_empty, rxq.size() == 0);
      cmp("m_rx_data",  rx_data,  (rxq.size() != 0) ? rxq[0] : 16'h0);
      cmp("m_rx_cnt",   rx_cnt,   rxq.size());
      cmp("m_err",      err,      err_m);
    end
  end

  task automatic step(input logic w, input logic [15:0] wd, input logic p,
                      input logic ps, input logic [15:0] pd, input logic r, input logic ec);
    tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r; err_clr = ec;
    @(posedge clk);
    @(negedge clk);
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_pndng"},    pndng,    1'b0);
    cmp({tag, "_D_pop"},    D_pop,    16'h0);
    cmp({tag, "_tx_full"},  tx_full,  1'b0);
    cmp({tag, "_rx_empty"}, rx_empty, 1'b1);
    cmp({tag, "_rx_data"},  rx_data,  16'h0);
    cmp({tag, "_tx_cnt"},   tx_cnt,   4'd0);
    cmp({tag, "_rx_cnt"},   rx_cnt,   4'd0);
    cmp({tag, "_err"},      err,      3'b000);
  endtask

  initial begin
    reset = 1'b1;
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
    tx_data = 16'h0; D_push = 16'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // TX basic
    step(1, 16'h0312, 0, 0, 16'h0, 0, 0);
    cmp("tx1_pndng", pndng, 1'b1);
    cmp("tx1_dpop", D_pop, 16'h0312);
    step(1, 16'h05AB, 0, 0, 16'h0, 0, 0);
    cmp("tx2_cnt", tx_cnt, 4'd2);
    cmp("tx2_dpop", D_pop, 16'h0312);
    step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cmp("tx3_dpop", D_pop, 16'h05AB);
    cmp("tx3_cnt", tx_cnt, 4'd1);
    step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cmp("tx4_pndng", pndng, 1'b0);
    cmp("tx4_cnt", tx_cnt, 4'd0);

    // TX full / overflow
    for (int i = 0; i < 8; i++) step(1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0, 0);
    cmp("ovf_full", tx_full, 1'b1);
    cmp("ovf_err0", err, 3'b000);
    step(1, 16'h01FF, 0, 0, 16'h0, 0, 0);
    cmp("ovf_err", err, 3'b010);
    cmp("ovf_cnt", tx_cnt, 4'd8);
    step(1, 16'h0120, 1, 0, 16'h0, 0, 0);
    cmp("wrpop_cnt", tx_cnt, 4'd8);
    cmp("wrpop_dpop", D_pop, 16'h0101);
    step(0, 16'h0, 0, 0, 16'h0, 0, 1);
    cmp("clr_err", err, 3'b000);
    for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cmp("drain_cnt", tx_cnt, 4'd0);

    // Underflow, and clear colliding with a new event
    step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cmp("unf_err", err, 3'b001);
    cmp("unf_cnt", tx_cnt, 4'd0);
    step(0, 16'h0, 1, 0, 16'h0, 0, 1);
    cmp("clr_vs_event", err, 3'b001);
    step(0, 16'h0, 0, 0, 16'h0, 0, 1);
    cmp("unf_clr", err, 3'b000);
    step(1, 16'h0777, 1, 0, 16'h0, 0, 0);
    cmp("wrpop_empty_err", err, 3'b001);
    cmp("wrpop_empty_cnt", tx_cnt, 4'd1);
    step(0, 16'h0, 1, 0, 16'h0, 0, 1);

    // RX basic, drop, push+read while full
    for (int i = 1; i <= 8; i++) step(0, 16'h0, 0, 1, {DEV, 8'(i)}, 0, 0);
    cmp("rx_cnt8", rx_cnt, 4'd8);
    cmp("rx_head", rx_data, {DEV, 8'h01});
    step(0, 16'h0, 0, 1, {DEV, 8'h09}, 0, 0);
    cmp("rx_drop_err", err, 3'b100);
    cmp("rx_drop_cnt", rx_cnt, 4'd8);
    step(0, 16'h0, 0, 1, {DEV, 8'h0A}, 1, 0);
    cmp("rx_pushrd_cnt", rx_cnt, 4'd8);
    cmp("rx_pushrd_head", rx_data, {DEV, 8'h02});
    for (int i = 2; i <= 8; i++) begin
      cmp("rx_order", rx_data, {DEV, 8'(i)});
      step(0, 16'h0, 0, 0, 16'h0, 1, 0);
    end
    cmp("rx_last", rx_data, {DEV, 8'h0A});
    step(0, 16'h0, 0, 0, 16'h0, 1, 0);
    step(0, 16'h0, 0, 0, 16'h0, 1, 1);
    cmp("rx_rd_empty_err", err, 3'b000);
    cmp("rx_rd_empty", rx_empty, 1'b1);

    // Destination filter
    step(0, 16'h0, 0, 1, 16'h0211, 0, 0);
    step(0, 16'h0, 0, 1, 16'h0322, 0, 0);
    step(0, 16'h0, 0, 1, 16'hFF33, 0, 0);
`ifdef BUS_DEV_RX_FILTER_EN
    cmp("flt_cnt", rx_cnt, 4'd2);
    cmp("flt_rd0", rx_data, 16'h0211);
    step(0, 16'h0, 0, 0, 16'h0, 1, 0);
    cmp("flt_rd1", rx_data, 16'hFF33);
`else
    cmp("nof_cnt", rx_cnt, 4'd3);
    cmp("nof_rd0", rx_data, 16'h0211);
    step(0, 16'h0, 0, 0, 16'h0, 1, 0);
    cmp("nof_rd1", rx_data, 16'h0322);
`endif
    cmp("flt_err", err, 3'b000);
    while (!rx_empty && checks < 100000) step(0, 16'h0, 0, 0, 16'h0, 1, 0);

    // Async reset mid-stream with 4 entries each side and a sticky error set
    step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 16'h1000 + 16'(i), 0, 1, {DEV, 8'h40 + 8'(i)}, 0, 0);
    cmp("pre_rst_tx", tx_cnt, 4'd4);
    cmp("pre_rst_rx", rx_cnt, 4'd4);
    cmp("pre_rst_err", err, 3'b001);
    #2 reset = 1'b1;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    check_reset_outputs("arst_hold");
    reset = 1'b0;
    @(negedge clk);
    step(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cmp("post_rst_unf", err, 3'b001);
    step(1, 16'h0ABC, 0, 0, 16'h0, 0, 1);
    cmp("post_rst_dpop", D_pop, 16'h0ABC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
- Synthesizable device-side endpoint of the bus generator/arbiter protocol; one instance per device slot.
- TX FIFO presents pndng/D_pop to the arbiter and retires the head on pop.
- RX FIFO captures D_push on push.
- Host logic writes outbound packets and reads inbound packets through simple valid/full/empty FIFO ports.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID in MSBs [pckg_sz-1 -: 8].
- depth, 8, entries per FIFO (power of 2, >=2).
- dev_id, 0, this device's 8-bit ID.
- broadcast, 8'hFF, destination ID meaning "all devices".

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- tx_wr  in  1  host write strobe into TX FIFO
- tx_data  in  pckg_sz  host outbound packet
- tx_full  out  1  TX FIFO full
- rx_rd  in  1  host read strobe from RX FIFO
- rx_data  out  pckg_sz  RX FIFO head (first-word-fall-through)
- rx_empty  out  1  RX FIFO empty
- pndng  out  1  to arbiter: TX FIFO non-empty
- D_pop  out  pckg_sz  to arbiter: TX FIFO head
- pop  in  1  from arbiter: retire TX head this cycle
- push  in  1  from arbiter: D_push valid this cycle
- D_push  in  pckg_sz  from arbiter: inbound packet
- tx_cnt  out  $clog2(depth+1)  TX occupancy
- rx_cnt  out  $clog2(depth+1)  RX occupancy
- err  out  3  sticky {rx_drop, tx_ovf, pop_underflow}
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset values: pndng=0, D_pop=0, tx_full=0, rx_empty=1, rx_data=0, tx_cnt=0, rx_cnt=0, err=0; pointers cleared. Reset mid-operation discards all FIFO contents.
- TX, FWFT:
  - pndng = (tx_cnt!=0). D_pop = head when pndng, else 0.
  - A written packet appears on pndng/D_pop the cycle after tx_wr (1-cycle latency).
  - pop with pndng=1 advances the head; the new head is visible the next cycle.
  - pop with pndng=0 is ignored and sets err[0].
  - tx_wr with tx_full=1 and no pop is dropped and sets err[1].
  - tx_wr and pop in the same cycle while full: write accepted, count unchanged.
  - tx_wr and pop in the same cycle while empty: pop ignored (sets err[0]), write accepted.
- RX, FWFT:
  - push with RX not full stores D_push; rx_empty falls the next cycle.
  - push while full with no rx_rd: packet dropped, err[2] set.
  - push and rx_rd in the same cycle while full: both proceed.
  - rx_rd while empty is ignored; no error is flagged.
- Occupancy: counts are updated as +1/-1/0 per cycle. Pointers are log2(depth) bits and wrap naturally from depth-1 to 0.
- err_clr: clears err on the next edge. A new error event in the same cycle wins, and the bit stays set.
- No combinational path from pop/push to any output except via registered state.

Optional Feature:
- Macro: BUS_DEV_RX_FILTER_EN.
- Defined: a push is stored only if dest ID == dev_id or dest ID == broadcast. Other pushes are silently discarded: no err, rx_cnt unchanged.
- Undefined: every push is stored regardless of dest ID.

Decomposition:
- Package bus_dev_pkg holds:
  - ID_W=8, BROADCAST_ID constant.
  - function dest_of(pkt) returning the MSB ID field.
  - typedef for the err bit indices.
- Sub-module bus_dev_fifo: parameterized FWFT sync FIFO with count. Instantiated twice, once for TX and once for RX. Error flag logic stays in the top level.

Test Plan:
- TX basic: after reset, write 16'h0312 then 16'h05AB, pop once per cycle when pndng. Required: D_pop shows 16'h0312 then 16'h05AB; pndng drops after the second pop; tx_cnt goes 2→1→0.
- TX full/overflow: 9 writes with depth=8. Required: tx_full=1 after the 8th; the 9th is dropped; err=3'b010. Then pop with tx_wr in the same cycle while full: tx_cnt stays 8.
- Underflow: pop with empty FIFO. Required: err=3'b001, no pointer movement. Then err_clr: err returns to 0 next cycle.
- RX basic and drop: 9 pushes of 16'h00_01..16'h00_09. Required: the first 8 are read back in order via rx_rd; the 9th is dropped with err[2]=1.
- Filter (BUS_DEV_RX_FILTER_EN, dev_id=2): push 16'h0211, 16'h0322, 16'hFF33. Required: rx_cnt=2; reads return 16'h0211 then 16'hFF33; err=0.
- Async reset mid-stream: assert reset between clock edges with 4 entries in each FIFO. Required: outputs take reset values immediately, before the next clk edge, and remain stable until release.
